hysteresis_saturating_counter_table: RTL and testbench

Indexed array of DEPTH independent hysteresis saturating counters, with one registered read port and one update port. Each entry behaves as a single hysteresis saturating counter: it saturates at both ends and jumps across the midpoint by COERCIVITY. Intended as the pattern history / confidence table of branch predictors and replacement-policy confidence trackers.

---
 rtl/hysteresis_saturating_counter_table.sv | 117 +++++++++++
 tb/tb_hysteresis_saturating_counter_table.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hysteresis_saturating_counter_table.sv
// hysteresis_saturating_counter_table
// Table of DEPTH independent hysteresis saturating counters with one
// registered read port (1-cycle latency) and one update port.
// Each counter saturates at 0 and WIDTH-1. It jumps across the midpoint by
// COERCIVITY, so one disagreeing outcome does not flip a strong decision.
// Optional build macro HYSTERESIS_SATURATING_COUNTER_TABLE_BYPASS_EN selects
// write-first forwarding from a same-cycle update or clear to the read port.
// The default build is read-first.
module hysteresis_saturating_counter_table #(
  parameter int WIDTH      = 4,
  parameter int WIDTH_LOG2 = $clog2(WIDTH),
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int RESET      = 0,
  parameter int COERCIVITY = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  read_enable,
  input  logic [DEPTH_LOG2-1:0] read_index,
  output logic                  read_valid,
  output logic [WIDTH_LOG2-1:0] read_count,
  output logic                  read_taken,
  input  logic                  update_enable,
  input  logic [DEPTH_LOG2-1:0] update_index,
  input  logic                  update_increment,
  input  logic                  update_decrement
);

  typedef logic [WIDTH_LOG2-1:0] count_t;

  localparam count_t MAX_VAL   = count_t'(WIDTH - 1);
  localparam count_t HALF_LOW  = count_t'(WIDTH / 2 - 1);
  localparam count_t HALF_HIGH = count_t'(WIDTH / 2);
  localparam count_t JUMP_HIGH = count_t'(WIDTH / 2 + COERCIVITY);
  localparam count_t JUMP_LOW  = count_t'(WIDTH / 2 - 1 - COERCIVITY);
  localparam count_t RESET_VAL = count_t'(RESET);
  localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);

  count_t table_q [DEPTH];
  logic   read_valid_q;
  count_t read_count_q;
  logic   read_taken_q;

  logic   update_hit;
  count_t update_cur;
  count_t update_next;
  count_t read_value_d;

  // One counter step. Increment has priority unless the counter is already at
  // the top, in which case a simultaneous decrement takes effect instead.
  function automatic count_t next_count(input count_t value, input logic inc,
                                        input logic dec);
    if (inc && value != MAX_VAL)
      return (value == HALF_LOW) ? JUMP_HIGH : value + 1'b1;
    else if (dec && value != '0)
      return (value == HALF_HIGH) ? JUMP_LOW : value - 1'b1;
    else
      return value;
  endfunction

  // Select the addressed entry and compute its post-update value.
  always_comb begin
    // NOTE: every comb output is assigned up front so no path can leave it
    // unassigned and infer a latch.
    update_hit  = update_enable && ({1'b0, update_index} < DEPTH_W);
    update_cur  = update_hit ? table_q[update_index] : RESET_VAL;
    update_next = next_count(update_cur, update_increment, update_decrement);
  end

  // Value presented to the read register; an out-of-range index reads RESET.
  always_comb begin
    read_value_d = ({1'b0, read_index} < DEPTH_W) ? table_q[read_index] : RESET_VAL;
`ifdef HYSTERESIS_SATURATING_COUNTER_TABLE_BYPASS_EN
    if (clear)
      read_value_d = RESET_VAL;
    else if (update_hit && update_index == read_index)
      read_value_d = update_next;
`endif
  end

  // Counter storage: async reset and sync clear restore RESET; clear drops updates.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the table is built from flops rather than a RAM macro because every
    // entry must return to RESET on both resetn and clear.
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= RESET_VAL;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= RESET_VAL;
    end else if (update_hit) begin
      // NOTE: non-blocking assignment, so the read port and update logic in this
      // cycle both see the pre-edge table contents.
      table_q[update_index] <= update_next;
    end
  end

  // Registered read port: valid follows the request, data holds when idle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      read_valid_q <= 1'b0;
      read_count_q <= '0;
      read_taken_q <= 1'b0;
    end else begin
      read_valid_q <= read_enable;
      if (read_enable) begin
        read_count_q <= read_value_d;
        read_taken_q <= (read_value_d >= HALF_HIGH);
      end
    end
  end

  assign read_valid = read_valid_q;
  assign read_count = read_count_q;
  assign read_taken = read_taken_q;

endmodule

// File: tb/tb_hysteresis_saturating_counter_table.sv
// Testbench for hysteresis_saturating_counter_table (WIDTH=8, DEPTH=12).
// Expected read results are queued when a read is driven.
// They are popped and compared when read_valid appears one cycle later.
module tb_hysteresis_saturating_counter_table;

  localparam int W   = 8;
  localparam int D   = 12;
  localparam int RST = 0;
  localparam int C   = 1;

  logic       clock = 1'b0;
  logic       resetn;
  logic       clear;
  logic       read_enable;
  logic [3:0] read_index;
  logic       read_valid;
  logic [2:0] read_count;
  logic       read_taken;
  logic       update_enable;
  logic [3:0] update_index;
  logic       update_increment;
  logic       update_decrement;

  hysteresis_saturating_counter_table #(
    .WIDTH(W), .DEPTH(D), .RESET(RST), .COERCIVITY(C)
  ) dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .read_enable(read_enable), .read_index(read_index),
    .read_valid(read_valid), .read_count(read_count), .read_taken(read_taken),
    .update_enable(update_enable), .update_index(update_index),
    .update_increment(update_increment), .update_decrement(update_decrement)
  );

  always #5 clock = ~clock;

  int mdl [D];
  int exp_q [$];
  int last_count;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference counter: saturating, jumps across the midpoint by C.
  function automatic int model_next(input int v, input bit inc, input bit dec);
    if (inc && v != W - 1) return (v == W / 2 - 1) ? (W / 2 + C) : (v + 1);
    if (dec && v != 0)     return (v == W / 2) ? (W / 2 - 1 - C) : (v - 1);
    return v;
  endfunction

  // One clock cycle of stimulus followed by the scoreboard check of the read port.
  // ovr >= 0 pins the expected read value to a hand-derived constant.
  task automatic step(input bit re, input int ridx, input bit ue, input int uidx,
                      input bit inc, input bit dec, input bit clr, input int ovr);
    int e;
    @(negedge clock);
    read_enable      = re;
    read_index       = 4'(ridx);
    update_enable    = ue;
    update_index     = 4'(uidx);
    update_increment = inc;
    update_decrement = dec;
    clear            = clr;
    if (re) begin
      e = (ridx < D) ? mdl[ridx] : RST;
`ifdef HYSTERESIS_SATURATING_COUNTER_TABLE_BYPASS_EN
      if (clr) e = RST;
      else if (ue && uidx < D && uidx == ridx) e = model_next(mdl[uidx], inc, dec);
`endif
      if (ovr >= 0) e = ovr;
      exp_q.push_back(e);
    end
    if (clr) begin
      for (int i = 0; i < D; i++) mdl[i] = RST;
    end else if (ue && uidx < D) begin
      mdl[uidx] = model_next(mdl[uidx], inc, dec);
    end
    @(posedge clock);
    #1;
    check("read_valid", 32'(read_valid), 32'(re));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (read_valid) begin
        check($sformatf("read_count[%0d]", ridx), 32'(read_count), 32'(e));
        check($sformatf("read_taken[%0d]", ridx), 32'(read_taken), 32'(e >= W / 2));
        last_count = e;
      end
    end else if (!read_valid) begin
      check("hold_count", 32'(read_count), 32'(last_count));
      check("hold_taken", 32'(read_taken), 32'(last_count >= W / 2));
    end
  endtask

  task automatic upd(input int idx, input bit inc, input bit dec);
    step(1'b0, 0, 1'b1, idx, inc, dec, 1'b0, -1);
  endtask

  task automatic rd(input int idx, input int ovr);
    step(1'b1, idx, 1'b0, 0, 1'b0, 1'b0, 1'b0, ovr);
  endtask

  task automatic reset_model();
    for (int i = 0; i < D; i++) mdl[i] = RST;
    exp_q.delete();
    last_count = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int inc_tbl [8] = '{1, 2, 3, 5, 6, 7, 7, 7};
    int dec_tbl [8] = '{6, 5, 4, 2, 1, 0, 0, 0};
    int same_exp;

    resetn = 1'b0; clear = 1'b0; read_enable = 1'b0; read_index = '0;
    update_enable = 1'b0; update_index = '0;
    update_increment = 1'b0; update_decrement = 1'b0;
    reset_model();
    #12;
    check("rst_valid", 32'(read_valid), 32'(0));
    check("rst_count", 32'(read_count), 32'(0));
    check("rst_taken", 32'(read_taken), 32'(0));
    @(negedge clock);
    resetn = 1'b1;

    // Increment sweep on index 3: jump at the midpoint, saturate at the top.
    for (int k = 0; k < 8; k++) begin
      upd(3, 1'b1, 1'b0);
      rd(3, inc_tbl[k]);
    end
    // Decrement sweep back down with the mirror jump and floor saturation.
    for (int k = 0; k < 8; k++) begin
      upd(3, 1'b0, 1'b1);
      rd(3, dec_tbl[k]);
    end

    // Both directions at once: increment wins except at the top.
    upd(2, 1'b1, 1'b0); upd(2, 1'b1, 1'b0);
    upd(2, 1'b1, 1'b1); rd(2, 3);
    upd(3, 1'b1, 1'b1); rd(3, 1);
    for (int k = 0; k < 6; k++) upd(4, 1'b1, 1'b0);
    rd(4, 7);
    upd(4, 1'b1, 1'b1); rd(4, 6);

    // Same-index read and update in one cycle.
    for (int k = 0; k < 3; k++) upd(5, 1'b1, 1'b0);
`ifdef HYSTERESIS_SATURATING_COUNTER_TABLE_BYPASS_EN
    same_exp = 5;
`else
    same_exp = 3;
`endif
    step(1'b1, 5, 1'b1, 5, 1'b1, 1'b0, 1'b0, same_exp);
    rd(5, 5);

    // Clear with a concurrent update and read: the update is dropped.
    step(1'b1, 2, 1'b1, 1, 1'b1, 1'b0, 1'b1, -1);
    for (int i = 0; i < D; i++) rd(i, RST);

    // Out-of-range update and read leave the table untouched and read RESET.
    upd(6, 1'b1, 1'b0);
    upd(13, 1'b1, 1'b0);
    rd(13, RST);
    for (int i = 0; i < D; i++) rd(i, -1);

    // Asynchronous reset in the middle of a read.
    upd(7, 1'b1, 1'b0); upd(7, 1'b1, 1'b0);
    rd(7, 2);
    @(negedge clock);
    read_enable = 1'b1; read_index = 4'd7; update_enable = 1'b0; clear = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("midrst_valid", 32'(read_valid), 32'(0));
    check("midrst_count", 32'(read_count), 32'(0));
    check("midrst_taken", 32'(read_taken), 32'(0));
    @(posedge clock);
    #1;
    check("midrst_valid_held", 32'(read_valid), 32'(0));
    @(negedge clock);
    resetn = 1'b1;
    read_enable = 1'b0;
    reset_model();
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < D; i++) rd(i, RST);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
